// File: rtl/pipe_exec_pkg.sv
// pipe_exec_pkg: state encodings and constants shared by the execution controller and debug snapshot decoding.
package pipe_exec_pkg;
  localparam int PIPE_DEPTH_DEF = 5;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_EN   = 3'd2,
    STEP_WAIT = 3'd3,
    DRAIN     = 3'd4,
    STOPPED   = 3'd5
  } state_t;
endpackage

// File: rtl/pipe_exec_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (en && q != '1) q <= q + W'(1);
endmodule

// File: rtl/pipe_exec_ctrl.sv
// pipe_exec_ctrl: turns debug run/step requests into the pipeline enable and drains the pipe on HALT.
// Optional run-mode watchdog is built when PIPE_EXEC_WDOG_EN is defined.
module pipe_exec_ctrl
  import pipe_exec_pkg::*;
#(
  parameter int PIPE_DEPTH  = PIPE_DEPTH_DEF,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_load_busy,
  input  logic               i_halt_fetched,
  input  logic               i_clear,
  output logic               o_pipe_en,
  output logic               o_stop,
  output logic [CNT_W-1:0]   o_cycle_cnt,
  output logic [STATE_W-1:0] o_state,
  output logic               o_timeout
);
  localparam int DW = $clog2(PIPE_DEPTH + 1);
  state_t state, state_n;
  logic en, en_n, run_flag, run_flag_n, stop, clr_cnt, wd_hit;
  logic [DW-1:0] dcnt, dcnt_n, remain;
  always_comb begin
    state_n    = state;
    en_n       = 1'b0;
    run_flag_n = run_flag;
    dcnt_n     = dcnt;
    clr_cnt    = 1'b0;
    remain     = (en && dcnt != '0) ? dcnt - DW'(1) : dcnt;
    case (state)
      IDLE, STEP_WAIT:
        if (!i_load_busy && i_run) begin
          state_n    = RUN;
          en_n       = 1'b1;
          run_flag_n = 1'b1;
        end else if (!i_load_busy && i_step) begin
          state_n    = STEP_EN;
          en_n       = 1'b1;
          run_flag_n = 1'b0;
        end
      RUN: en_n = !i_load_busy;
      STEP_EN:
        if (en) state_n = STEP_WAIT;
        else en_n = !i_load_busy;
      DRAIN: begin
        dcnt_n  = remain;
        state_n = (remain == '0) ? STOPPED : DRAIN;
        en_n    = remain != '0 && !i_load_busy && (run_flag || i_step);
      end
      STOPPED:
        if (i_clear) begin
          state_n    = IDLE;
          clr_cnt    = 1'b1;
          run_flag_n = 1'b0;
        end
      default: state_n = IDLE;
    endcase
    // HALT seen while enabled starts the drain; instructions behind it are don't-care
    if (en && i_halt_fetched && state != DRAIN) begin
      dcnt_n  = DW'(PIPE_DEPTH - 1);
      state_n = (PIPE_DEPTH == 1) ? STOPPED : DRAIN;
      en_n    = PIPE_DEPTH > 1 && run_flag && !i_load_busy;
    end
    if (wd_hit) begin
      state_n = STOPPED;
      en_n    = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      en       <= 1'b0;
      run_flag <= 1'b0;
      dcnt     <= '0;
      stop     <= 1'b0;
    end else begin
      state    <= state_n;
      en       <= en_n;
      run_flag <= run_flag_n;
      dcnt     <= dcnt_n;
      stop     <= state_n == STOPPED;
    end
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst(rst), .clr(clr_cnt), .en(en), .q(o_cycle_cnt)
  );
`ifdef PIPE_EXEC_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wcnt;
  logic timeout;
  sat_counter #(.W(WW)) u_wdog_cnt (
    .clk(clk), .rst(rst), .clr(state_n == RUN && state != RUN),
    .en(en && run_flag), .q(wcnt)
  );
  assign wd_hit = en && run_flag && wcnt == WW'(WDOG_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst) timeout <= 1'b0;
    else if (wd_hit) timeout <= 1'b1;
    else if (state == STOPPED && i_clear) timeout <= 1'b0;
  assign o_timeout = timeout;
`else
  assign wd_hit    = 1'b0;
  assign o_timeout = 1'b0 && (WDOG_CYCLES > 0);
`endif
  assign o_pipe_en = en;
  assign o_stop    = stop;
  assign o_state   = state;
endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// tb_pipe_exec_ctrl: scoreboard bench for pipe_exec_ctrl, plus a depth-1 / 2-bit-counter instance for boundaries.
module tb_pipe_exec_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic i_run = 1'b0, i_step = 1'b0, i_load_busy = 1'b0, i_halt_fetched = 1'b0, i_clear = 1'b0;
  logic o_pipe_en, o_stop, o_timeout, p_en, p_stop, p_timeout;
  logic [31:0] o_cycle_cnt;
  logic [1:0] p_cnt;
  logic [2:0] o_state, p_state;
  int checks = 0, failures = 0;
  logic exp_q[$];
  logic [1:0] pair_q[$], pair2_q[$];

  always #5 clk = ~clk;

  pipe_exec_ctrl #(.PIPE_DEPTH(5), .CNT_W(32), .WDOG_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_step(i_step), .i_load_busy(i_load_busy),
    .i_halt_fetched(i_halt_fetched), .i_clear(i_clear), .o_pipe_en(o_pipe_en), .o_stop(o_stop),
    .o_cycle_cnt(o_cycle_cnt), .o_state(o_state), .o_timeout(o_timeout)
  );

  pipe_exec_ctrl #(.PIPE_DEPTH(1), .CNT_W(2), .WDOG_CYCLES(20)) dut1 (
    .clk(clk), .rst(rst), .i_run(i_run), .i_step(i_step), .i_load_busy(i_load_busy),
    .i_halt_fetched(i_halt_fetched), .i_clear(i_clear), .o_pipe_en(p_en), .o_stop(p_stop),
    .o_cycle_cnt(p_cnt), .o_state(p_state), .o_timeout(p_timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    {i_run, i_step, i_load_busy, i_halt_fetched, i_clear} = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clk);
    checks++;
    if ({o_pipe_en, o_stop, o_timeout, o_state} !== 6'b0 || o_cycle_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset: en=%b stop=%b to=%b state=%0d cnt=%0d, all required 0",
               o_pipe_en, o_stop, o_timeout, o_state, o_cycle_cnt);
    end
    tick;
  endtask

  task automatic test_run;
    logic [1:0] e;
    do_reset;
    for (int c = 0; c <= 14; c++) begin
      pair_q.push_back({c >= 1 && c <= 11, c >= 12});
      pair2_q.push_back({c >= 1 && c <= 7, c >= 8});
    end
    i_run = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      i_halt_fetched = (c == 7);
      @(negedge clk);
      e = pair_q.pop_front();
      checks++;
      if ({o_pipe_en, o_stop} !== e) begin
        failures++;
        $display("FAIL run_en_stop cycle %0d: got %b required %b", c, {o_pipe_en, o_stop}, e);
      end
      e = pair2_q.pop_front();
      checks++;
      if ({p_en, p_stop} !== e) begin
        failures++;
        $display("FAIL depth1_en_stop cycle %0d: got %b required %b", c, {p_en, p_stop}, e);
      end
      tick;
      i_run = 1'b0;
    end
    i_halt_fetched = 1'b0;
    @(negedge clk);
    checks++;
    if (o_cycle_cnt !== 32'd11 || o_state !== 3'd5 || o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL run_end: cnt=%0d state=%0d to=%b required 11/5/0", o_cycle_cnt, o_state, o_timeout);
    end
    checks++;
    if (p_cnt !== 2'd3 || p_state !== 3'd5) begin
      failures++;
      $display("FAIL depth1_sat: cnt=%0d state=%0d required 3/5", p_cnt, p_state);
    end
    tick;
    i_run = 1'b1;
    i_step = 1'b1;
    tick;
    i_run = 1'b0;
    i_step = 1'b0;
    @(negedge clk);
    checks++;
    if (o_pipe_en !== 1'b0 || o_stop !== 1'b1 || o_state !== 3'd5) begin
      failures++;
      $display("FAIL stopped_ignore: en=%b stop=%b state=%0d required 0/1/5", o_pipe_en, o_stop, o_state);
    end
    tick;
    i_clear = 1'b1;
    tick;
    i_clear = 1'b0;
    @(negedge clk);
    checks++;
    if (o_stop !== 1'b0 || o_cycle_cnt !== 32'd0 || o_state !== 3'd0 || p_cnt !== 2'd0) begin
      failures++;
      $display("FAIL clear: stop=%b cnt=%0d state=%0d cnt1=%0d required 0/0/0/0",
               o_stop, o_cycle_cnt, o_state, p_cnt);
    end
    tick;
  endtask

  task automatic test_step;
    logic e;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int k = 0; k <= 12; k++) begin
      i_step = (k % 4 == 0) && k <= 8;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (o_pipe_en !== e) begin
        failures++;
        $display("FAIL step_en cycle %0d: got %b required %b", k, o_pipe_en, e);
      end
      exp_q.push_back(i_step);
      tick;
    end
    i_step = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (o_cycle_cnt !== 32'd3 || o_state !== 3'd3) begin
      failures++;
      $display("FAIL step_end: cnt=%0d state=%0d required 3/3", o_cycle_cnt, o_state);
    end
    tick;
  endtask

  task automatic test_step_halt;
    logic e;
    do_reset;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int k = 0; k <= 21; k++) begin
      i_step = (k % 3 == 0);
      i_halt_fetched = (k >= 3);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (o_pipe_en !== e) begin
        failures++;
        $display("FAIL step_halt_en cycle %0d: got %b required %b", k, o_pipe_en, e);
      end
      checks++;
      if (o_stop !== (k >= 17)) begin
        failures++;
        $display("FAIL step_halt_stop cycle %0d: got %b required %b", k, o_stop, k >= 17);
      end
      exp_q.push_back(i_step && k <= 15);
      tick;
    end
    i_step = 1'b0;
    i_halt_fetched = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (o_cycle_cnt !== 32'd6 || o_state !== 3'd5) begin
      failures++;
      $display("FAIL step_halt_end: cnt=%0d state=%0d required 6/5", o_cycle_cnt, o_state);
    end
    tick;
  endtask

  task automatic test_busy;
    do_reset;
    i_load_busy = 1'b1;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    i_step = 1'b1;
    tick;
    i_step = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_pipe_en !== 1'b0 || o_state !== 3'd0) begin
        failures++;
        $display("FAIL busy_idle %0d: en=%b state=%0d required 0/0", k, o_pipe_en, o_state);
      end
      tick;
    end
    i_load_busy = 1'b0;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    @(negedge clk);
    checks++;
    if (o_pipe_en !== 1'b1 || o_state !== 3'd1) begin
      failures++;
      $display("FAIL busy_release: en=%b state=%0d required 1/1", o_pipe_en, o_state);
    end
    tick;
    i_load_busy = 1'b1;
    tick;
    i_load_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (o_pipe_en !== 1'b0 || o_state !== 3'd1) begin
      failures++;
      $display("FAIL busy_run: en=%b state=%0d required 0/1", o_pipe_en, o_state);
    end
    tick;
    @(negedge clk);
    checks++;
    if (o_pipe_en !== 1'b1) begin
      failures++;
      $display("FAIL busy_run_resume: en=%b required 1", o_pipe_en);
    end
    tick;
  endtask

  task automatic test_rst_drain;
    do_reset;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    i_halt_fetched = 1'b1;
    tick;
    i_halt_fetched = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_state !== 3'd4 || o_pipe_en !== 1'b1 || o_cycle_cnt !== 32'd3) begin
      failures++;
      $display("FAIL pre_rst_drain: state=%0d en=%b cnt=%0d required 4/1/3", o_state, o_pipe_en, o_cycle_cnt);
    end
    tick;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_pipe_en, o_stop, o_timeout, o_state} !== 6'b0 || o_cycle_cnt !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_drain: en=%b stop=%b to=%b state=%0d cnt=%0d required all 0",
               o_pipe_en, o_stop, o_timeout, o_state, o_cycle_cnt);
    end
    tick;
  endtask

`ifdef PIPE_EXEC_WDOG_EN
  task automatic test_wdog;
    logic e;
    do_reset;
    exp_q.delete();
    for (int c = 0; c <= 25; c++) exp_q.push_back(c >= 1 && c <= 20);
    i_run = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (o_pipe_en !== e) begin
        failures++;
        $display("FAIL wdog_en cycle %0d: got %b required %b", c, o_pipe_en, e);
      end
      tick;
      i_run = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (o_stop !== 1'b1 || o_timeout !== 1'b1 || o_cycle_cnt !== 32'd20) begin
      failures++;
      $display("FAIL wdog_end: stop=%b to=%b cnt=%0d required 1/1/20", o_stop, o_timeout, o_cycle_cnt);
    end
    tick;
    i_clear = 1'b1;
    tick;
    i_clear = 1'b0;
    @(negedge clk);
    checks++;
    if (o_timeout !== 1'b0 || o_stop !== 1'b0) begin
      failures++;
      $display("FAIL wdog_clear: to=%b stop=%b required 0/0", o_timeout, o_stop);
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_run;
    test_step;
    test_step_halt;
    test_busy;
    test_rst_drain;
`ifdef PIPE_EXEC_WDOG_EN
    test_wdog;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
